// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared types, defaults and one-hot helper for ring bus consumers
package ring_pkg;

    typedef enum logic {HUNT, LOCK} ring_dec_state_t;

    localparam int RING_N     = 4;
    localparam int RING_REV_W = 8;

    // Zero-extension keeps the one-hot property, so any ring up to 64 bits fits.
    function automatic bit onehot_check(input logic [63:0] vec);
        return (vec != 64'd0) && ((vec & (vec - 64'd1)) == 64'd0);
    endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// rtl/ring_onehot_enc.sv - combinational one-hot to binary encoder with one-hot flag
module ring_onehot_enc
    import ring_pkg::*;
#(
    parameter int N  = RING_N,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  ring_in,
    output logic [IW-1:0] pos,
    output logic          onehot
);

    // OR of set-bit indices; only meaningful when onehot is high.
    always_comb begin
        pos = '0;
        for (int i = 0; i < N; i++) begin
            if (ring_in[i]) begin
                pos = pos | IW'(i);
            end
        end
    end

    assign onehot = onehot_check(64'(ring_in));

endmodule

// File: rtl/ring_decoder.sv
// rtl/ring_decoder.sv - one-hot ring phase decoder and integrity monitor (option: RING_DECODER_ERRCNT_EN)
module ring_decoder
    import ring_pkg::*;
#(
    parameter int N     = RING_N,
    parameter int IW    = $clog2(N),
    parameter int REV_W = RING_REV_W
`ifdef RING_DECODER_ERRCNT_EN
    ,
    parameter int ERR_W = 4
`endif
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic [N-1:0]     ring_in,
    input  logic             in_valid,
`ifdef RING_DECODER_ERRCNT_EN
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_count,
`endif
    output logic [IW-1:0]    idx,
    output logic             idx_valid,
    output logic             locked,
    output logic             onehot_err,
    output logic             seq_err,
    output logic [REV_W-1:0] rev_count,
    output logic             wrap
);

    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    ring_dec_state_t  state, state_nx;
    logic [IW-1:0]    pos, exp_pos, idx_nx;
    logic             onehot;
    logic             idx_valid_nx, onehot_err_nx, seq_err_nx, wrap_nx;
    logic [REV_W-1:0] rev_nx;

    ring_onehot_enc #(.N(N), .IW(IW)) u_enc (
        .ring_in (ring_in),
        .pos     (pos),
        .onehot  (onehot)
    );

    always_comb begin
        state_nx      = state;
        idx_nx        = idx;
        rev_nx        = rev_count;
        idx_valid_nx  = 1'b0;
        onehot_err_nx = 1'b0;
        seq_err_nx    = 1'b0;
        wrap_nx       = 1'b0;
        exp_pos       = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        if (in_valid) begin
            if (!onehot) begin
                onehot_err_nx = 1'b1;
                state_nx      = HUNT;
            end else begin
                idx_nx       = pos;
                idx_valid_nx = 1'b1;
                if (state == HUNT) begin
                    rev_nx   = '0;
                    state_nx = LOCK;
                end else if (pos == exp_pos) begin
                    if (idx == IDX_LAST) begin
                        wrap_nx = 1'b1;
                        rev_nx  = rev_count + 1'b1;
                    end
                end else begin
                    // Out-of-sequence phase: relock on it and restart the revolution count.
                    seq_err_nx = 1'b1;
                    rev_nx     = '0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            state      <= HUNT;
            idx        <= '0;
            idx_valid  <= 1'b0;
            onehot_err <= 1'b0;
            seq_err    <= 1'b0;
            wrap       <= 1'b0;
            rev_count  <= '0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            idx_valid  <= idx_valid_nx;
            onehot_err <= onehot_err_nx;
            seq_err    <= seq_err_nx;
            wrap       <= wrap_nx;
            rev_count  <= rev_nx;
        end
    end

    assign locked = (state == LOCK);

`ifdef RING_DECODER_ERRCNT_EN
    // Counts alongside the error pulse so err_count and the pulse appear together.
    always_ff @(posedge clock) begin
        if (Reset || err_clr) begin
            err_count <= '0;
        end else if ((onehot_err_nx || seq_err_nx) && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

endmodule
